// File: rtl/icosoc_mod_ledpanel_rx_pkg.sv
// Shared constants and types for the HUB75 receive-side capture block.
package icosoc_mod_ledpanel_rx_pkg;

    localparam int COLS_PER_PANEL = 32;
    localparam int ROWS           = 32;

    localparam logic [15:0] ADDR_COUNTERS = 16'h8000;
    localparam logic [15:0] ADDR_STATUS   = 16'h8004;

    // Bit positions of the panel pins in the 13-bit sampled vector.
    localparam int PIN_COUNT   = 13;
    localparam int PIN_ROW_LSB = 6;
    localparam int PIN_CLK     = 10;
    localparam int PIN_STB     = 11;
    localparam int PIN_OE      = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OE = 2'd1,
        COPY    = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [5:0] colour;    // {r0, g0, b0, r1, g1, b1}
        logic       clk_rise;
        logic       stb_rise;
        logic       oe_fall;
    } panel_ev_t;

endpackage

// File: rtl/ledpanel_rx_sync.sv
// Register chain plus history stage for the 13 panel pins; data levels are taken
// from the history stage so they line up with the edge flags.
module ledpanel_rx_sync
    import icosoc_mod_ledpanel_rx_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIN_COUNT-1:0] pins,
    output panel_ev_t            ev
);

    logic [PIN_COUNT-1:0] chain [STAGES];
    logic [PIN_COUNT-1:0] hist;
    logic [PIN_COUNT-1:0] level;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
            hist <= '0;
        end else begin
            chain[0] <= pins;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            hist <= level;
        end
    end

    assign level       = chain[STAGES-1];
    assign ev.row      = hist[PIN_ROW_LSB+3:PIN_ROW_LSB];
    assign ev.colour   = hist[5:0];
    assign ev.clk_rise = level[PIN_CLK] & ~hist[PIN_CLK];
    assign ev.stb_rise = level[PIN_STB] & ~hist[PIN_STB];
    assign ev.oe_fall  = ~level[PIN_OE] & hist[PIN_OE];

endmodule

// File: rtl/icosoc_mod_ledpanel_rx.sv
// HUB75 capture: shifts panel columns into a line buffer, copies each strobed line
// into per-plane pixel memories, and serves pixels and status over the ctrl bus.
module icosoc_mod_ledpanel_rx
    import icosoc_mod_ledpanel_rx_pkg::*;
#(
    parameter int BITS_PER_CHANNEL = 4,
    parameter int SIZE             = 1,
    parameter int SYNC_STAGES      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [15:0] ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    input  logic        panel_r0,
    input  logic        panel_g0,
    input  logic        panel_b0,
    input  logic        panel_r1,
    input  logic        panel_g1,
    input  logic        panel_b1,
    input  logic        panel_a,
    input  logic        panel_b,
    input  logic        panel_c,
    input  logic        panel_d,
    input  logic        panel_clk,
    input  logic        panel_stb,
    input  logic        panel_oe
);

    localparam int NCOLS  = COLS_PER_PANEL * SIZE;
    localparam int CW     = $clog2(NCOLS);
    localparam int PW     = CW + 5;
    localparam int HW     = CW + 4;
    localparam int HDEPTH = NCOLS * (ROWS / 2);
    localparam int PLW    = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
    localparam logic [CW:0]    COL_MAX    = (CW+1)'(NCOLS);
    localparam logic [PLW-1:0] PLANE_LAST = PLW'(BITS_PER_CHANNEL - 1);

    logic [PIN_COUNT-1:0] pins;
    panel_ev_t            ev;
    rx_state_t            state, state_next;

    logic [5:0]     line [NCOLS];
    logic [5:0]     hold [NCOLS];
    logic [CW:0]    col, hold_cnt, k;
    logic [3:0]     row;
    logic [PLW-1:0] plane;
    logic           seen_strobe;
    logic [15:0]    frame_cnt, ovr_cnt;
    logic           long_row;
    logic           clk_take, stb_take, stb_drop, row_take, copy_we, copy_last, stat_clear;
    logic           unused_wdat;

    assign pins = {panel_oe, panel_stb, panel_clk, panel_d, panel_c, panel_b, panel_a,
                   panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1};
    assign unused_wdat = ^ctrl_wdat;

    ledpanel_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .pins  (pins),
        .ev    (ev)
    );

    assign clk_take = ev.clk_rise && (col < COL_MAX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ev.stb_rise) state_next = WAIT_OE;
            WAIT_OE: if (ev.oe_fall)  state_next = COPY;
            COPY:    if (copy_last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stb_take  = (state == IDLE) && ev.stb_rise;
        stb_drop  = (state != IDLE) && ev.stb_rise;
        row_take  = (state == WAIT_OE) && ev.oe_fall;
        copy_we   = (state == COPY) && (k < hold_cnt);
        copy_last = (state == COPY) && (k + 1'b1 >= hold_cnt);
    end

    // Every strobe restarts the column position, even one that is dropped as an overrun.
    always_ff @(posedge clk) begin
        if (reset)            col <= '0;
        else if (ev.stb_rise) col <= '0;
        else if (clk_take)    col <= col + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clk_take) line[col[CW-1:0]] <= ev.colour;
    end

    // A clock edge coinciding with the strobe lands in the copied line.
    always_ff @(posedge clk) begin
        if (stb_take) begin
            for (int i = 0; i < NCOLS; i++)
                hold[i] <= (clk_take && col[CW-1:0] == CW'(i)) ? ev.colour : line[i];
            hold_cnt <= clk_take ? col + 1'b1 : col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row         <= '0;
            plane       <= '0;
            seen_strobe <= 1'b0;
            k           <= '0;
        end else if (row_take) begin
            row         <= ev.row;
            seen_strobe <= 1'b1;
            k           <= '0;
            if (seen_strobe && ev.row == row)
                plane <= (plane == PLANE_LAST) ? '0 : plane + 1'b1;
            else
                plane <= '0;
        end else if (copy_we) begin
            k <= k + 1'b1;
        end
    end

    // Each plane is split on pixel address bit 4 so both panel halves land in one cycle.
    logic [2:0]    mem_top [BITS_PER_CHANNEL][HDEPTH];
    logic [2:0]    mem_bot [BITS_PER_CHANNEL][HDEPTH];
    logic [HW-1:0] wr_idx;
    assign wr_idx = {k[CW-1:0], row};

    always_ff @(posedge clk) begin
        if (copy_we) begin
            mem_top[plane][wr_idx] <= hold[k[CW-1:0]][5:3];
            mem_bot[plane][wr_idx] <= hold[k[CW-1:0]][2:0];
        end
    end

    assign stat_clear = ctrl_wr && !ctrl_done && (ctrl_addr == ADDR_COUNTERS);

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            frame_cnt <= '0;
            ovr_cnt   <= '0;
            long_row  <= 1'b0;
        end else begin
            if (copy_last && row == 4'd15 && plane == PLANE_LAST) frame_cnt <= frame_cnt + 1'b1;
            if (stb_drop && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 1'b1;
            if (ev.clk_rise && !clk_take) long_row <= 1'b1;
        end
    end

    logic [PW-1:0] pix;
    logic [HW-1:0] rd_idx;
    logic [2:0]    px_bits;
    logic [31:0]   pix_word;
    assign pix    = ctrl_addr[PW+1:2];
    assign rd_idx = {pix[PW-1:5], pix[3:0]};

    // Plane p supplies channel bit (8 - BITS_PER_CHANNEL + p); low bits stay zero.
    always_comb begin
        pix_word = '0;
        px_bits  = '0;
        for (int p = 0; p < BITS_PER_CHANNEL; p++) begin
            px_bits = pix[4] ? mem_bot[p][rd_idx] : mem_top[p][rd_idx];
            pix_word[16 + 8 - BITS_PER_CHANNEL + p] = px_bits[2];
            pix_word[8 + 8 - BITS_PER_CHANNEL + p]  = px_bits[1];
            pix_word[8 - BITS_PER_CHANNEL + p]      = px_bits[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_done <= 1'b0;
            ctrl_rdat <= '0;
        end else begin
            ctrl_done <= (ctrl_wr || ctrl_rd) && !ctrl_done;
            ctrl_rdat <= '0;
            if (ctrl_rd && !ctrl_done) begin
                if (!ctrl_addr[15])                  ctrl_rdat <= pix_word;
                else if (ctrl_addr == ADDR_COUNTERS) ctrl_rdat <= {frame_cnt, ovr_cnt};
                else if (ctrl_addr == ADDR_STATUS)   ctrl_rdat <= {29'b0, long_row, state};
            end
        end
    end

endmodule

// File: tb/tb_icosoc_mod_ledpanel_rx.sv
// Random panel traffic against a frame-level model; bus reads are scored from a queue.
module tb_icosoc_mod_ledpanel_rx;

    localparam int BPC   = 4;
    localparam int NCOLS = 32;
    localparam int NPIX  = NCOLS * 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_wr = 1'b0, ctrl_rd = 1'b0;
    logic [15:0] ctrl_addr = '0;
    logic [31:0] ctrl_wdat = '0;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic        panel_r0 = 0, panel_g0 = 0, panel_b0 = 0, panel_r1 = 0, panel_g1 = 0, panel_b1 = 0;
    logic        panel_a = 0, panel_b = 0, panel_c = 0, panel_d = 0;
    logic        panel_clk = 0, panel_stb = 0, panel_oe = 0;

    always #5 clk = ~clk;

    icosoc_mod_ledpanel_rx #(.BITS_PER_CHANNEL(BPC), .SIZE(1), .SYNC_STAGES(1)) dut (
        .clk(clk), .reset(reset),
        .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
        .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_a(panel_a), .panel_b(panel_b), .panel_c(panel_c), .panel_d(panel_d),
        .panel_clk(panel_clk), .panel_stb(panel_stb), .panel_oe(panel_oe)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    // Model: one 3-bit {r,g,b} sample per plane per pixel, pixel = column*32 + display row.
    logic [2:0] m_mem [BPC][NPIX];
    int m_last_row = -1, m_last_plane = 0, m_frame = 0, m_ovr = 0;
    bit m_long = 1'b0;

    logic [31:0] mon_e;
    bit          mon_c;
    string       mon_n;

    always @(negedge clk) begin
        if (ctrl_done) begin
            if (chk_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=%08h required=no response", ctrl_rdat);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = chk_q.pop_front();
                mon_n = name_q.pop_front();
                if (mon_c) begin
                    checks++;
                    if (ctrl_rdat !== mon_e) begin
                        failures++;
                        $display("FAIL %s got=%08h required=%08h", mon_n, ctrl_rdat, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input int a, input logic [31:0] e, input string n);
        exp_q.push_back(e); chk_q.push_back(1'b1); name_q.push_back(n);
        ctrl_addr = 16'(a); ctrl_rd = 1'b1;
        cyc(1);
        ctrl_rd = 1'b0;
        cyc(1);
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        exp_q.push_back('0); chk_q.push_back(1'b0); name_q.push_back("write");
        ctrl_addr = 16'(a); ctrl_wdat = d; ctrl_wr = 1'b1;
        cyc(1);
        ctrl_wr = 1'b0;
        cyc(1);
        if (a == 32'h8000) begin
            m_frame = 0; m_ovr = 0; m_long = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_pixel(input int pix);
        int r = 0, g = 0, b = 0;
        for (int p = 0; p < BPC; p++) begin
            if (m_mem[p][pix][2]) r += 1 << (8 - BPC + p);
            if (m_mem[p][pix][1]) g += 1 << (8 - BPC + p);
            if (m_mem[p][pix][0]) b += 1 << (8 - BPC + p);
        end
        return {8'h00, 8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [31:0] exp_counters();
        return {16'(m_frame), 16'(m_ovr)};
    endfunction

    task automatic model_reset();
        m_last_row = -1; m_last_plane = 0; m_frame = 0; m_ovr = 0; m_long = 1'b0;
    endtask

    task automatic model_row(input int row, input logic [5:0] d[$]);
        int plane;
        plane = (row == m_last_row) ? (m_last_plane + 1) % BPC : 0;
        m_last_row = row;
        m_last_plane = plane;
        for (int c = 0; c < d.size() && c < NCOLS; c++) begin
            m_mem[plane][c*32 + row]      = d[c][5:3];
            m_mem[plane][c*32 + row + 16] = d[c][2:0];
        end
        if (d.size() > NCOLS) m_long = 1'b1;
        if (row == 15 && plane == BPC - 1) m_frame++;
    endtask

    // Shift n random columns, strobe, present the row, then drop oe.
    task automatic send_row(input int row, input int n, input bit upd);
        logic [5:0] d[$];
        logic [5:0] v;
        panel_oe = 1'b1;
        for (int c = 0; c < n; c++) begin
            v = 6'($urandom_range(0, 63));
            d.push_back(v);
            {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = v;
            cyc(2);
            panel_clk = 1'b1;
            cyc(2);
            panel_clk = 1'b0;
        end
        panel_stb = 1'b1;
        cyc(2);
        panel_stb = 1'b0;
        {panel_d, panel_c, panel_b, panel_a} = 4'(row);
        cyc(2);
        panel_oe = 1'b0;
        if (upd) model_row(row, d);
    endtask

    task automatic check_row(input int row, input int ncol);
        for (int c = 0; c < ncol; c++) begin
            bus_read((c*32 + row) * 4, exp_pixel(c*32 + row), "pix_top");
            bus_read((c*32 + row + 16) * 4, exp_pixel(c*32 + row + 16), "pix_bot");
        end
    endtask

    initial begin
        for (int p = 0; p < BPC; p++)
            for (int i = 0; i < NPIX; i++) m_mem[p][i] = '0;

        cyc(3);
        reset = 1'b0;
        checks++;
        if (ctrl_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%0b required=0", ctrl_done);
        end
        bus_read(32'h8000, exp_counters(), "reset_counters");
        bus_read(32'h8004, 32'h0, "reset_status");

        // Full frame: every row, every plane.
        for (int r = 0; r < 16; r++)
            for (int p = 0; p < BPC; p++) begin
                send_row(r, NCOLS, 1'b1);
                cyc(40);
            end
        for (int i = 0; i < NPIX; i++) bus_read(i * 4, exp_pixel(i), "frame_pix");
        bus_read(32'h8000, exp_counters(), "frame_counters");

        // Short row leaves columns beyond the tenth untouched.
        send_row(3, 10, 1'b1);
        cyc(20);
        check_row(3, 12);
        bus_read(32'h8004, {29'b0, m_long, 2'b00}, "short_status");

        // Long row: only the first 32 clocks are kept.
        send_row(5, 40, 1'b1);
        cyc(45);
        check_row(5, NCOLS);
        bus_read(32'h8004, {29'b0, m_long, 2'b00}, "long_status");
        bus_write(32'h8000, 32'h0);
        bus_read(32'h8004, {29'b0, m_long, 2'b00}, "clear_status");
        bus_read(32'h8000, exp_counters(), "clear_counters");

        // Repeated row walks the planes and wraps.
        for (int j = 0; j < BPC + 1; j++) begin
            send_row(7, NCOLS, 1'b1);
            cyc(40);
        end
        check_row(7, NCOLS);
        for (int j = 0; j < BPC; j++) begin
            send_row(15, NCOLS, 1'b1);
            cyc(40);
        end
        bus_read(32'h8000, exp_counters(), "frame_count");

        // Overrun: second strobe while the copy is running.
        send_row(11, NCOLS, 1'b1);
        cyc(5);
        panel_stb = 1'b1;
        cyc(2);
        panel_stb = 1'b0;
        m_ovr++;
        cyc(40);
        bus_read(32'h8004, {29'b0, m_long, 2'b00}, "ovr_status");
        bus_read(32'h8000, exp_counters(), "ovr_counters");
        check_row(11, NCOLS);
        bus_write(32'h8000, 32'h0);
        bus_read(32'h8000, exp_counters(), "ovr_cleared");

        // Reset ten cycles into a copy.
        send_row(9, NCOLS, 1'b0);
        cyc(12);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        model_reset();
        checks++;
        if (ctrl_done !== 1'b0) begin
            failures++;
            $display("FAIL midcopy_done got=%0b required=0", ctrl_done);
        end
        bus_read(32'h8004, 32'h0, "midcopy_status");
        bus_read(32'h8000, exp_counters(), "midcopy_counters");
        send_row(9, NCOLS, 1'b1);
        cyc(40);
        check_row(9, NCOLS);

        cyc(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_reads got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
